fnd_scan_controller: RTL and testbench



---
 rtl/fnd_scan_controller_pkg.sv | 47 ++++
 rtl/fnd_scan_controller_if.sv | 15 +
 rtl/fnd_scan_controller_bin2bcd_seq.sv | 71 +++++++
 rtl/fnd_scan_controller.sv | 82 ++++++++
 tb/tb_fnd_scan_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// fnd_pkg: shared constants, FSM state type and helper functions for the
// FND scan controller (segment patterns, double-dabble step).
package fnd_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned VALUE_W   = 14;
  localparam int unsigned MAX_VALUE = 9999;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned SR_W      = BCD_W + VALUE_W;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; codes 10-15 cannot occur and show blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    logic [3:0]      nib;
    s = sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = s[VALUE_W + 4*i +: 4];
      if (nib >= 4'd5) s[VALUE_W + 4*i +: 4] = nib + 4'd3;
    end
    return {s[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if: load/busy handshake between a value producer
// (master) and the scan controller (slave).
//   i_value : binary value to display
//   i_load  : single-cycle load strobe
//   o_busy  : conversion in progress
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic [VALUE_W-1:0] i_value;
  logic               i_load;
  logic               o_busy;

  modport master (output i_value, output i_load, input o_busy);
  modport slave  (input i_value, input i_load, output o_busy);
endinterface

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : start strobe, ignored while busy
//   value_i       : binary input, clamped to MAX_VALUE on load
//   busy_o        : high during the VALUE_W conversion iterations
//   bcd_o         : last completed result, updated only when a run finishes
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int unsigned MAX_V = MAX_VALUE
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               busy_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam logic [VALUE_W-1:0] MAX_BIN  = VALUE_W'(MAX_V);
  localparam logic [3:0]         LAST_IT  = 4'(VALUE_W - 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          sr_d    = {{BCD_W{1'b0}}, (value_i > MAX_BIN) ? MAX_BIN : value_i};
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = dd_step(sr_q);
        cnt_d = cnt_q + 4'd1;
        // Commit straight from the final shift so the result lands with busy low.
        if (cnt_q == LAST_IT) begin
          bcd_d   = sr_d[SR_W-1 -: BCD_W];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o = (state_q == CONVERT);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: converts a binary value to BCD and multiplexes the
// four digits onto a common-anode 7-segment display, one digit per rising
// edge of the slow scan clock.
//   i_clk      : system clock
//   i_reset_n  : async active-low reset
//   i_scan_clk : slow scan square wave, treated as asynchronous data
//   bus        : load/value/busy handshake (slave side)
//   o_seg      : active-low segments {dp,g,f,e,d,c,b,a}
//   o_com      : active-low one-hot digit select, bit 0 = units
// Build option: define FND_LZB_EN for leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned MAX_V = MAX_VALUE
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_scan_clk,
  fnd_scan_controller_if.slave  bus,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_com
);

  logic [BCD_W-1:0] bcd;
  logic [2:0]       sync_q;
  logic             scan_rise;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       com_q, com_d;
  logic [3:0]       digit;
  logic             lz_blank;

  bin2bcd_seq #(
    .MAX_V (MAX_V)
  ) u_conv (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .load_i  (bus.i_load),
    .value_i (bus.i_value),
    .busy_o  (bus.o_busy),
    .bcd_o   (bcd)
  );

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= '0;
    else            sync_q <= {sync_q[1:0], i_scan_clk};
  end

  assign scan_rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    idx_d = (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
    digit = bcd[4*idx_d +: 4];
`ifdef FND_LZB_EN
    lz_blank = (idx_d != 2'd0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_d) && bcd[4*i +: 4] != 4'd0) lz_blank = 1'b0;
    end
`else
    lz_blank = 1'b0;
`endif
    seg_d = lz_blank ? SEG_BLANK : seg_decode(digit);
    com_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q <= 2'd3;
      seg_q <= SEG_BLANK;
      com_q <= '1;
    end else if (scan_rise) begin
      idx_q <= idx_d;
      seg_q <= seg_d;
      com_q <= com_d;
    end
  end

  assign o_seg = seg_q;
  assign o_com = com_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;
  import fnd_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       scan_clk;
  logic [7:0] seg;
  logic [3:0] com;

  fnd_scan_controller_if bus ();

  fnd_scan_controller dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_scan_clk (scan_clk),
    .bus        (bus.slave),
    .o_seg      (seg),
    .o_com      (com)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: displayed decimal value, current digit, last registered outputs.
  int         disp_m;
  int         idx_m;
  logic [3:0] com_exp;
  logic [7:0] seg_exp;
  logic [7:0] seg_tab [10];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input int val, input int idx);
    int d;
    d = (val / pow10(idx)) % 10;
`ifdef FND_LZB_EN
    if (idx > 0 && val < pow10(idx)) return 8'hFF;
`endif
    return seg_tab[d];
  endfunction

  task automatic model_advance();
    idx_m   = (idx_m + 1) % 4;
    com_exp = 4'hF & ~(4'(1) << idx_m);
    seg_exp = exp_seg(disp_m, idx_m);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_com"}, 32'(com), 32'(com_exp));
    check_eq({tag, "_seg"}, 32'(seg), 32'(seg_exp));
  endtask

  // Rising scan edge: outputs must hold for two cycles, change on the third,
  // and ignore the following falling edge.
  task automatic scan_edge();
    @(negedge clk); scan_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("lat_hold_com", 32'(com), 32'(com_exp));
    @(negedge clk);
    model_advance();
    check_outputs("scan");
    scan_clk = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("fall_hold");
  endtask

  task automatic do_load(input int v, input int mid_v, input bit scan_end);
    int n;
    @(negedge clk);
    bus.i_load  = 1'b1;
    bus.i_value = 14'(v);
    @(negedge clk);
    bus.i_load = 1'b0;
    n = 0;
    while (bus.o_busy === 1'b1 && n < 40) begin
      n++;
      if (mid_v >= 0 && n == 5) begin
        bus.i_load  = 1'b1;
        bus.i_value = 14'(mid_v);
      end else begin
        bus.i_load = 1'b0;
      end
      if (scan_end && n == 14) scan_clk = 1'b1;
      @(negedge clk);
    end
    bus.i_load = 1'b0;
    check_eq("busy_len", 32'(n), 32'd14);
    disp_m = (v > MAX_VALUE) ? MAX_VALUE : v;
    check_outputs("upd_hold");
    if (scan_end) begin
      @(negedge clk);
      check_outputs("coinc_hold");
      @(negedge clk);
      model_advance();
      check_outputs("coinc_new");
      scan_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic scan_all();
    for (int i = 0; i < 4; i++) scan_edge();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst_n       = 1'b0;
    scan_clk    = 1'b0;
    bus.i_load  = 1'b0;
    bus.i_value = '0;
    disp_m  = 0;
    idx_m   = 3;
    com_exp = 4'hF;
    seg_exp = 8'hFF;

    repeat (3) @(negedge clk);
    check_outputs("rst");
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("post_rst");
    check_eq("post_rst_busy", 32'(bus.o_busy), 32'd0);

    // First edge after reset selects digit 0 showing "0".
    scan_edge();
    check_eq("first_com", 32'(com), 32'h0000_000E);
    check_eq("first_seg", 32'(seg), 32'h0000_00C0);

    do_load(1234, -1, 1'b0);
    scan_all();
    scan_edge();

    do_load(12000, -1, 1'b0);
    scan_all();

    do_load(42, 7, 1'b0);
    scan_all();

    // Reset in the middle of a conversion of 5678.
    @(negedge clk);
    bus.i_load  = 1'b1;
    bus.i_value = 14'd5678;
    @(negedge clk);
    bus.i_load = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    disp_m  = 0;
    idx_m   = 3;
    com_exp = 4'hF;
    seg_exp = 8'hFF;
    check_eq("abort_busy", 32'(bus.o_busy), 32'd0);
    check_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("abort_idle", 32'(bus.o_busy), 32'd0);
    check_outputs("abort_blank");
    scan_all();

    // Scan edge sampled on the very cycle busy drops.
    do_load(8765, -1, 1'b1);
    scan_all();

    for (int it = 0; it < 14; it++) begin
      int v, mid, ne;
      v   = int'($urandom_range(0, 16383));
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16383)) : -1;
      do_load(v, mid, $urandom_range(0, 3) == 0);
      ne = int'($urandom_range(1, 5));
      for (int k = 0; k < ne; k++) scan_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
